// File: rtl/corr_pkg.sv
// Package: corr_pkg
// Shared constants, the per-channel count triple and the logdrop weighting
// function for the multi-channel windowed correlation counter.
//   CORR_DATA_W / CORR_TIME_W : default counter width / window-time width
//   wt_width()                : weight width derived from counter and time widths
//   WINMODE_RECT / _LOGDROP   : window weighting selectors
//   chan_cnt_t                : {y, isect, symd} counts of one channel at default width
//   logdropWindow()           : weight = full >> (number of significant bits of t)
package corr_pkg;

   localparam int CORR_DATA_W = 16;
   localparam int CORR_TIME_W = 8;

   // The weight uses whatever bits the window length leaves free in the counter,
   // so a full window of maximum weights always fits without overflow.
   function automatic int wt_width(input int data_w, input int time_w);
      return data_w - time_w;
   endfunction

   localparam int CORR_WT_W = wt_width(CORR_DATA_W, CORR_TIME_W);

   localparam logic WINMODE_RECT    = 1'b0;
   localparam logic WINMODE_LOGDROP = 1'b1;

   typedef struct packed {
      logic [CORR_DATA_W-1:0] y;
      logic [CORR_DATA_W-1:0] isect;
      logic [CORR_DATA_W-1:0] symd;
   } chan_cnt_t;

   // Weight halves each time t gains a significant bit: t=0 -> full,
   // t=1 -> full>>1, t=2..3 -> full>>2, t=4..7 -> full>>3, ...
   function automatic logic [31:0] logdropWindow(input logic [31:0] t,
                                                 input logic [31:0] full);
      logic [5:0] nbits;
      nbits = '0;
      for (int b = 0; b < 32; b++) begin
         if (t[b]) nbits = 6'(b + 1);
      end
      return full >> nbits;
   endfunction

endpackage

// File: rtl/corr_chan_acc.sv
// Module: corr_chan_acc
// One y channel's three weighted accumulators (y, x&y, x^y) plus the snapshot
// registers that hold the final sums of the most recent window.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_acc_en     : accumulate this cycle (stage-1 sample valid and clock enabled)
//   i_snap       : this accumulation is the window's last; capture the sums
//   i_first      : this accumulation is the window's first; start from zero
//   i_w          : zero-extended sample weight
//   i_x, i_y     : registered reference and channel bits
//   o_y, o_isect, o_symd : snapshot counts
module corr_chan_acc #(
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_acc_en,
   input  logic              i_snap,
   input  logic              i_first,
   input  logic [DATA_W-1:0] i_w,
   input  logic              i_x,
   input  logic              i_y,
   output logic [DATA_W-1:0] o_y,
   output logic [DATA_W-1:0] o_isect,
   output logic [DATA_W-1:0] o_symd
);

   logic [DATA_W-1:0] y_q, isect_q, symd_q;
   logic [DATA_W-1:0] y_d, isect_d, symd_d;
   logic [DATA_W-1:0] snap_y_q, snap_isect_q, snap_symd_q;
   logic [DATA_W-1:0] snap_y_d, snap_isect_d, snap_symd_d;
   logic [DATA_W-1:0] y_sum, isect_sum, symd_sum;

   always_comb begin
      // The first sample of a window discards the previous window's totals.
      y_sum     = (i_first ? '0 : y_q)     + ((i_y)         ? i_w : '0);
      isect_sum = (i_first ? '0 : isect_q) + ((i_x & i_y)   ? i_w : '0);
      symd_sum  = (i_first ? '0 : symd_q)  + ((i_x ^ i_y)   ? i_w : '0);

      y_d          = y_q;
      isect_d      = isect_q;
      symd_d       = symd_q;
      snap_y_d     = snap_y_q;
      snap_isect_d = snap_isect_q;
      snap_symd_d  = snap_symd_q;
      if (i_acc_en) begin
         y_d     = y_sum;
         isect_d = isect_sum;
         symd_d  = symd_sum;
      end
      if (i_snap) begin
         snap_y_d     = y_sum;
         snap_isect_d = isect_sum;
         snap_symd_d  = symd_sum;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         y_q          <= '0;
         isect_q      <= '0;
         symd_q       <= '0;
         snap_y_q     <= '0;
         snap_isect_q <= '0;
         snap_symd_q  <= '0;
      end else begin
         y_q          <= y_d;
         isect_q      <= isect_d;
         symd_q       <= symd_d;
         snap_y_q     <= snap_y_d;
         snap_isect_q <= snap_isect_d;
         snap_symd_q  <= snap_symd_d;
      end
   end

   assign o_y     = snap_y_q;
   assign o_isect = snap_isect_q;
   assign o_symd  = snap_symd_q;

endmodule

// File: rtl/corr_count_multi.sv
// Module: corr_count_multi
// Correlates one reference bitstream x against N_CH channel bitstreams over
// windows of 2**TIME_W enabled samples, with rectangular or logdrop weighting
// chosen per window. Final window sums are snapshotted into a valid/ready
// output register with a sticky overrun flag.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_cg          : clock-gate enable; all state holds when low
//   i_en          : sample enable; low inserts a bubble
//   i_x, i_y      : reference bit, channel bits
//   i_winMode     : 0 rectangular, 1 logdrop; taken at each window start
//   o_t           : current window time
//   o_valid/i_ready : snapshot handshake
//   o_countX, o_countY, o_countIsect, o_countSymd : snapshot counts
//   o_overrun     : sticky, a snapshot was overwritten before being consumed
module corr_count_multi
   import corr_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int DATA_W = CORR_DATA_W,
   parameter int TIME_W = CORR_TIME_W
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_cg,
   input  logic                   i_en,
   input  logic                   i_x,
   input  logic [N_CH-1:0]        i_y,
   input  logic                   i_winMode,
   output logic [TIME_W-1:0]      o_t,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [DATA_W-1:0]      o_countX,
   output logic [N_CH*DATA_W-1:0] o_countY,
   output logic [N_CH*DATA_W-1:0] o_countIsect,
   output logic [N_CH*DATA_W-1:0] o_countSymd,
   output logic                   o_overrun
);

   localparam int WT_W = wt_width(DATA_W, TIME_W);
   localparam logic [TIME_W-1:0] T_MAX   = '1;
   localparam logic [WT_W-1:0]   WT_ONES = '1;

   logic [TIME_W-1:0] t_q, t_d;
   logic              mode_q, mode_d;
   logic              s1_valid_q, s1_valid_d;
   logic [WT_W-1:0]   s1_w_q, s1_w_d;
   logic              s1_x_q, s1_x_d;
   logic [N_CH-1:0]   s1_y_q, s1_y_d;
   logic              s1_first_q, s1_first_d;
   logic              s1_last_q, s1_last_d;
   logic [DATA_W-1:0] acc_x_q, acc_x_d;
   logic [DATA_W-1:0] snap_x_q, snap_x_d;
   logic              valid_q, valid_d;
   logic              overrun_q, overrun_d;

   logic              at_start, mode_eff, acc_en, snap_take;
   logic [WT_W-1:0]   w_comb;
   logic [DATA_W-1:0] w_ext, x_sum;

   always_comb begin
      at_start = (t_q == '0);
      // The window's first sample already uses the mode being latched with it.
      mode_eff = at_start ? i_winMode : mode_q;
      w_comb   = (mode_eff == WINMODE_LOGDROP)
                 ? WT_W'(logdropWindow(32'(t_q), 32'(WT_ONES))) : WT_ONES;

      t_d    = (i_cg && i_en) ? t_q + 1'b1 : t_q;
      mode_d = (i_cg && i_en && at_start) ? i_winMode : mode_q;

      s1_valid_d = s1_valid_q;
      s1_w_d     = s1_w_q;
      s1_x_d     = s1_x_q;
      s1_y_d     = s1_y_q;
      s1_first_d = s1_first_q;
      s1_last_d  = s1_last_q;
      if (i_cg) begin
         s1_valid_d = i_en;
         s1_w_d     = w_comb;
         s1_x_d     = i_x;
         s1_y_d     = i_y;
         s1_first_d = at_start;
         s1_last_d  = (t_q == T_MAX);
      end

      acc_en    = i_cg & s1_valid_q;
      snap_take = acc_en & s1_last_q;
      w_ext     = {{TIME_W{1'b0}}, s1_w_q};
      x_sum     = (s1_first_q ? '0 : acc_x_q) + (s1_x_q ? w_ext : '0);
      acc_x_d   = acc_en ? x_sum : acc_x_q;
      snap_x_d  = snap_take ? x_sum : snap_x_q;

      // A landing snapshot wins over an accept in the same cycle; it only
      // counts as an overrun if the previous one was still being refused.
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (i_cg) begin
         if (snap_take) begin
            valid_d = 1'b1;
            if (valid_q && !i_ready) overrun_d = 1'b1;
         end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         t_q        <= '0;
         mode_q     <= WINMODE_RECT;
         s1_valid_q <= 1'b0;
         s1_w_q     <= '0;
         s1_x_q     <= 1'b0;
         s1_y_q     <= '0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         acc_x_q    <= '0;
         snap_x_q   <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         t_q        <= t_d;
         mode_q     <= mode_d;
         s1_valid_q <= s1_valid_d;
         s1_w_q     <= s1_w_d;
         s1_x_q     <= s1_x_d;
         s1_y_q     <= s1_y_d;
         s1_first_q <= s1_first_d;
         s1_last_q  <= s1_last_d;
         acc_x_q    <= acc_x_d;
         snap_x_q   <= snap_x_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      corr_chan_acc #(
         .DATA_W (DATA_W)
      ) u_acc (
         .i_clk    (i_clk),
         .i_rst    (i_rst),
         .i_acc_en (acc_en),
         .i_snap   (snap_take),
         .i_first  (s1_first_q),
         .i_w      (w_ext),
         .i_x      (s1_x_q),
         .i_y      (s1_y_q[gi]),
         .o_y      (o_countY[gi*DATA_W +: DATA_W]),
         .o_isect  (o_countIsect[gi*DATA_W +: DATA_W]),
         .o_symd   (o_countSymd[gi*DATA_W +: DATA_W])
      );
   end

   assign o_t       = t_q;
   assign o_valid   = valid_q;
   assign o_countX  = snap_x_q;
   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_corr_count_multi.sv
// Testbench for corr_count_multi (N_CH=4, DATA_W=16, TIME_W=8).
// A window-level model accumulates weighted counts per window and hands the
// totals to the output register one clock-enabled cycle after the last sample.
module tb_corr_count_multi;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int TW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, cg, en, x, mode, ready;
   logic [N-1:0]  y;
   logic [TW-1:0] o_t;
   logic          o_valid, o_overrun;
   logic [DW-1:0] o_countX;
   logic [N*DW-1:0] o_countY, o_countIsect, o_countSymd;

   corr_count_multi #(.N_CH(N), .DATA_W(DW), .TIME_W(TW)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_cg         (cg),
      .i_en         (en),
      .i_x          (x),
      .i_y          (y),
      .i_winMode    (mode),
      .o_t          (o_t),
      .o_valid      (o_valid),
      .i_ready      (ready),
      .o_countX     (o_countX),
      .o_countY     (o_countY),
      .o_countIsect (o_countIsect),
      .o_countSymd  (o_countSymd),
      .o_overrun    (o_overrun)
   );

   int vectors = 0;
   int miscompares = 0;
   int checks = 0;
   int snaps_seen = 0;

   // model state
   int m_t;
   bit m_mode;
   int s_x, s_y[N], s_i[N], s_s[N];       // running window sums
   bit p_pend;
   int p_x, p_y[N], p_i[N], p_s[N];       // finished window awaiting landing
   bit e_valid, e_ovr;
   int e_x, e_y[N], e_i[N], e_s[N];       // expected output register

   function automatic int model_weight(input int t, input bit m);
      int nb, v;
      if (!m) return 255;
      nb = 0;
      v  = t;
      while (v > 0) begin
         nb++;
         v = v / 2;
      end
      return 255 / (1 << nb);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d (t=%0d, time %0t)", name, act, exp, m_t, $time);
      end
   endtask

   task automatic model_update();
      if (rst) begin
         m_t = 0; m_mode = 0; s_x = 0; p_pend = 0; p_x = 0;
         e_valid = 0; e_ovr = 0; e_x = 0;
         for (int c = 0; c < N; c++) begin
            s_y[c] = 0; s_i[c] = 0; s_s[c] = 0;
            p_y[c] = 0; p_i[c] = 0; p_s[c] = 0;
            e_y[c] = 0; e_i[c] = 0; e_s[c] = 0;
         end
      end else if (cg) begin
         if (p_pend) begin
            if (e_valid && !ready) e_ovr = 1;
            if (e_valid && ready) begin
               snaps_seen++;
               $display("snapshot %0d accepted: X=%0d Y0=%0d I0=%0d S0=%0d", snaps_seen, e_x, e_y[0], e_i[0], e_s[0]);
            end
            e_valid = 1;
            e_x = p_x;
            for (int c = 0; c < N; c++) begin
               e_y[c] = p_y[c]; e_i[c] = p_i[c]; e_s[c] = p_s[c];
            end
            p_pend = 0;
         end else if (e_valid && ready) begin
            snaps_seen++;
            $display("snapshot %0d accepted: X=%0d Y0=%0d I0=%0d S0=%0d", snaps_seen, e_x, e_y[0], e_i[0], e_s[0]);
            e_valid = 0;
         end
         if (en) begin
            int w;
            if (m_t == 0) begin
               m_mode = mode;
               s_x = 0;
               for (int c = 0; c < N; c++) begin
                  s_y[c] = 0; s_i[c] = 0; s_s[c] = 0;
               end
            end
            w = model_weight(m_t, m_mode);
            if (x) s_x += w;
            for (int c = 0; c < N; c++) begin
               if (y[c]) s_y[c] += w;
               if (x && y[c]) s_i[c] += w;
               if (x != y[c]) s_s[c] += w;
            end
            if (m_t == 255) begin
               p_pend = 1;
               p_x = s_x;
               for (int c = 0; c < N; c++) begin
                  p_y[c] = s_y[c]; p_i[c] = s_i[c]; p_s[c] = s_s[c];
               end
            end
            m_t = (m_t + 1) % 256;
         end
      end
   endtask

   task automatic compare();
      chk("t", 64'(o_t), 64'(m_t));
      chk("valid", 64'(o_valid), 64'(e_valid));
      chk("overrun", 64'(o_overrun), 64'(e_ovr));
      chk("countX", 64'(o_countX), 64'(e_x));
      for (int c = 0; c < N; c++) begin
         chk($sformatf("countY%0d", c), 64'(o_countY[c*DW +: DW]), 64'(e_y[c]));
         chk($sformatf("isect%0d", c), 64'(o_countIsect[c*DW +: DW]), 64'(e_i[c]));
         chk($sformatf("symd%0d", c), 64'(o_countSymd[c*DW +: DW]), 64'(e_s[c]));
         if (o_valid) begin
            int iv, sv, xv, yv;
            iv = int'(o_countIsect[c*DW +: DW]);
            sv = int'(o_countSymd[c*DW +: DW]);
            xv = int'(o_countX);
            yv = int'(o_countY[c*DW +: DW]);
            chk($sformatf("identity%0d", c), 64'(iv + sv), 64'(xv + yv - iv));
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_update();
      #1;
      compare();
      vectors++;
   endtask

   task automatic idle(input int n);
      en = 0;
      repeat (n) cyc();
   endtask

   initial begin
      int s, guard, pulses;
      rst = 1; cg = 1; en = 0; x = 0; y = '0; mode = 0; ready = 0;
      repeat (3) cyc();
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_countX", 64'(o_countX), 64'd0);
      rst = 0;

      // 1: rectangular, x=1, fixed channel relations
      for (int i = 0; i < 256; i++) begin
         en = 1; x = 1; y = {~x, x, 1'b0, 1'b1};
         cyc();
      end
      idle(2);
      chk("t1_valid", 64'(o_valid), 64'd1);
      chk("t1_countX", 64'(o_countX), 64'd65280);
      chk("t1_y0", 64'(o_countY[15:0]), 64'd65280);
      chk("t1_isect0", 64'(o_countIsect[15:0]), 64'd65280);
      chk("t1_symd0", 64'(o_countSymd[15:0]), 64'd0);
      chk("t1_y1", 64'(o_countY[31:16]), 64'd0);
      chk("t1_symd1", 64'(o_countSymd[31:16]), 64'd65280);
      ready = 1;
      cyc();
      chk("t1_consumed", 64'(o_valid), 64'd0);
      for (int i = 0; i < 256; i++) begin
         en = 1; x = 1'($urandom); y = {~x, x, 1'b0, 1'b1};
         cyc();
      end
      idle(3);

      // 2: logdrop, x=1, y=0
      ready = 0; mode = 1;
      for (int i = 0; i < 256; i++) begin
         en = 1; x = 1; y = '0;
         cyc();
      end
      idle(2);
      chk("t2_countX", 64'(o_countX), 64'd1024);
      chk("t2_symd0", 64'(o_countSymd[15:0]), 64'd1024);
      chk("t2_symd3", 64'(o_countSymd[63:48]), 64'd1024);
      chk("t2_isect2", 64'(o_countIsect[47:32]), 64'd0);
      ready = 1; mode = 0;
      cyc();

      // 3: two windows unconsumed -> overrun
      ready = 0;
      for (int i = 0; i < 512; i++) begin
         en = 1; x = 1'($urandom); y = 4'($urandom);
         cyc();
      end
      idle(2);
      chk("t3_valid", 64'(o_valid), 64'd1);
      chk("t3_overrun", 64'(o_overrun), 64'd1);
      ready = 1;
      cyc();
      chk("t3_valid_after", 64'(o_valid), 64'd0);
      chk("t3_overrun_sticky", 64'(o_overrun), 64'd1);

      // 4: mode toggle at t=100, random bubbles
      for (int win = 0; win < 2; win++) begin
         s = 0; guard = 0;
         while (s < 256 && guard < 5000) begin
            en = ($urandom_range(0, 2) != 0);
            x = 1'($urandom); y = 4'($urandom);
            mode = (win == 1) || (s >= 100);
            cyc();
            if (en) s++;
            guard++;
         end
         chk("t4_guard", 64'(s), 64'd256);
      end
      idle(3);

      // 5: gated mid-window, then reset at t=128
      mode = 0;
      for (int i = 0; i < 60; i++) begin
         en = 1; x = 1'($urandom); y = 4'($urandom);
         cyc();
      end
      cg = 0;
      for (int i = 0; i < 10; i++) begin
         en = 1'($urandom); x = 1'($urandom); y = 4'($urandom);
         ready = 1'($urandom); mode = 1'($urandom);
         cyc();
      end
      cg = 1; ready = 1; mode = 0;
      guard = 0;
      while (m_t != 128 && guard < 300) begin
         en = 1; x = 1'($urandom); y = 4'($urandom);
         cyc();
         guard++;
      end
      chk("t5_reach128", 64'(o_t), 64'd128);
      rst = 1;
      cyc();
      rst = 0;
      chk("t5_t", 64'(o_t), 64'd0);
      chk("t5_valid", 64'(o_valid), 64'd0);
      chk("t5_countX", 64'(o_countX), 64'd0);
      chk("t5_overrun", 64'(o_overrun), 64'd0);
      for (int i = 0; i < 20; i++) begin
         en = 1; x = 1'($urandom); y = 4'($urandom);
         cyc();
      end
      chk("t5_no_snap", 64'(o_valid), 64'd0);

      // 6: back-to-back windows, always ready
      pulses = 0;
      ready = 1;
      for (int i = 0; i < 236 + 3 * 256; i++) begin
         en = 1; x = 1'($urandom); y = 4'($urandom); mode = 1'($urandom);
         cyc();
         if (o_valid) pulses++;
      end
      en = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (o_valid) pulses++;
      end
      chk("t6_pulses", 64'(pulses), 64'd4);
      chk("t6_overrun", 64'(o_overrun), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
